// File: rtl/bldc_duty_scheduler.sv
// rtl/bldc_duty_scheduler.sv - round-robin duty ramp sequencer with reversal dwell, fault latch and command watchdog
module bldc_duty_scheduler #(
    parameter int NUM_MOTORS    = 5,
    parameter int DUTY_WIDTH    = 10,
    parameter int RAMP_STEP     = 4,
    parameter int TICK_DIV      = 1152,
    parameter int WDT_TICKS     = 1600,
    parameter int REVERSE_DWELL = 16
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_cmd_valid,
    output logic                             o_cmd_ready,
    input  logic [2:0]                       i_cmd_motor,
    input  logic [DUTY_WIDTH-1:0]            i_cmd_duty,
    input  logic [NUM_MOTORS-1:0]            i_connected,
    input  logic                             i_fault_clear,
    output logic [NUM_MOTORS*DUTY_WIDTH-1:0] o_duty,
    output logic [NUM_MOTORS-1:0]            o_en,
    output logic [NUM_MOTORS-1:0]            o_fault,
    output logic                             o_wdt_expired
);

    localparam int MW = DUTY_WIDTH - 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int DW = $clog2(REVERSE_DWELL + 1);
    localparam int WW = $clog2(WDT_TICKS + 1);

    localparam logic [PW-1:0] LP_PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] LP_IDX_LAST  = IW'(NUM_MOTORS - 1);
    localparam logic [MW-1:0] LP_STEP      = MW'(RAMP_STEP);
    localparam logic [DW-1:0] LP_DWELL     = DW'(REVERSE_DWELL);
    localparam logic [WW-1:0] LP_WDT_LAST  = WW'(WDT_TICKS - 1);
    localparam logic [3:0]    LP_NM        = 4'(NUM_MOTORS);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           w_idx_next;

    logic [PW-1:0]           r_presc;
    logic [WW-1:0]           r_wdt_cnt;
    logic                    r_wdt;
    logic                    r_ready;
    logic [NUM_MOTORS-1:0]   r_en;
    logic [NUM_MOTORS-1:0]   r_fault;
    logic [DUTY_WIDTH-1:0]   r_target [NUM_MOTORS];
    logic [DUTY_WIDTH-1:0]   r_duty   [NUM_MOTORS];
    logic [DW-1:0]           r_dwell  [NUM_MOTORS];

    logic                    w_tick;
    logic                    w_cmd_ok;
    logic                    w_wdt_fire;
    logic                    w_upd;
    logic [NUM_MOTORS-1:0]   w_fault_set;

    logic [DUTY_WIDTH-1:0]   w_cur;
    logic [DUTY_WIDTH-1:0]   w_tgt;
    logic [DW-1:0]           w_dwell_cur;
    logic                    w_cur_s;
    logic                    w_tgt_s;
    logic [MW-1:0]           w_cur_m;
    logic [MW-1:0]           w_tgt_m;
    logic [MW-1:0]           w_diff;
    logic [MW-1:0]           w_delta;
    logic [MW-1:0]           w_new_m;
    logic [DUTY_WIDTH-1:0]   w_upd_duty;
    logic [DW-1:0]           w_upd_dwell;

    // Commands to a nonexistent motor are swallowed: no target write, no watchdog kick.
    assign w_tick      = (r_presc == LP_PRESC_MAX);
    assign w_cmd_ok    = i_cmd_valid & r_ready & ({1'b0, i_cmd_motor} < LP_NM);
    assign w_wdt_fire  = w_tick & ~r_wdt & ~w_cmd_ok & (r_wdt_cnt == LP_WDT_LAST);
    assign w_upd       = (r_state == S_UPDATE);
    assign w_fault_set = r_en & ~i_connected;

    assign o_cmd_ready   = r_ready;
    assign o_en          = r_en;
    assign o_fault       = r_fault;
    assign o_wdt_expired = r_wdt;

    // Flatten per-motor applied duty onto the output bus.
    always_comb begin
        o_duty = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            o_duty[i*DUTY_WIDTH +: DUTY_WIDTH] = r_duty[i];
        end
    end

    // Ready comes up on the first edge out of reset and then stays high.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    // Free-running ramp tick prescaler.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Sequencer state and motor index register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Sequencer: a tick launches one pass over all motors, one motor per cycle.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_next = S_UPDATE;
                    w_idx_next   = '0;
                end
            end
            S_UPDATE: begin
                if (r_idx == LP_IDX_LAST) begin
                    w_state_next = S_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + IW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    // Shared ramp engine: next duty and dwell for the motor in the current slot.
    always_comb begin
        w_cur       = r_duty[r_idx];
        w_tgt       = (r_fault[r_idx] | r_wdt) ? '0 : r_target[r_idx];
        w_dwell_cur = r_dwell[r_idx];
        w_cur_s     = w_cur[DUTY_WIDTH-1];
        w_cur_m     = w_cur[MW-1:0];
        w_tgt_s     = w_tgt[DUTY_WIDTH-1];
        w_tgt_m     = w_tgt[MW-1:0];
        w_diff      = '0;
        w_delta     = '0;
        w_new_m     = '0;
        w_upd_duty  = w_cur;
        w_upd_dwell = w_dwell_cur;
        if (w_cur_m == '0) begin
            if (w_dwell_cur != '0) begin
                // Parked at zero: burn dwell, keep the old sign.
                w_upd_dwell = w_dwell_cur - DW'(1);
            end else begin
                // Launch from zero in the target direction.
                w_delta    = (w_tgt_m < LP_STEP) ? w_tgt_m : LP_STEP;
                w_upd_duty = {w_tgt_s, w_delta};
            end
        end else begin
            if (w_cur_s != w_tgt_s) begin
                // Wrong direction: ramp magnitude down toward zero first.
                w_delta = (w_cur_m < LP_STEP) ? w_cur_m : LP_STEP;
                w_new_m = w_cur_m - w_delta;
            end else if (w_tgt_m >= w_cur_m) begin
                w_diff  = w_tgt_m - w_cur_m;
                w_delta = (w_diff < LP_STEP) ? w_diff : LP_STEP;
                w_new_m = w_cur_m + w_delta;
            end else begin
                w_diff  = w_cur_m - w_tgt_m;
                w_delta = (w_diff < LP_STEP) ? w_diff : LP_STEP;
                w_new_m = w_cur_m - w_delta;
            end
            w_upd_duty = {w_cur_s, w_new_m};
            if (w_new_m == '0) begin
                w_upd_dwell = LP_DWELL;
            end
        end
    end

    // Target store: watchdog wipes all, fault_clear wipes connected motors, a command writes last.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                r_target[i] <= '0;
            end
        end else if (w_wdt_fire) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                r_target[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (i_fault_clear && i_connected[i]) begin
                    r_target[i] <= '0;
                end
                if (w_cmd_ok && (i_cmd_motor == 3'(i))) begin
                    r_target[i] <= i_cmd_duty;
                end
            end
        end
    end

    // Applied duty and dwell: watchdog and fault force zero, otherwise the slot owner takes the ramp result.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                r_duty[i]  <= '0;
                r_dwell[i] <= '0;
            end
        end else if (w_wdt_fire) begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                r_duty[i]  <= '0;
                r_dwell[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (w_fault_set[i]) begin
                    r_duty[i]  <= '0;
                    r_dwell[i] <= '0;
                end else if (w_upd && (r_idx == IW'(i))) begin
                    r_duty[i]  <= w_upd_duty;
                    r_dwell[i] <= w_upd_dwell;
                end
            end
        end
    end

    // Fault latch and enables: enables drop with the causing edge and return one edge after the cause clears.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fault <= '0;
            r_en    <= '0;
        end else begin
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (w_fault_set[i]) begin
                    r_fault[i] <= 1'b1;
                end else if (i_fault_clear && i_connected[i]) begin
                    r_fault[i] <= 1'b0;
                end
                r_en[i] <= ~(w_fault_set[i] | w_wdt_fire | r_fault[i] | r_wdt);
            end
        end
    end

    // Command watchdog: counts ticks since the last accepted in-range command.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wdt_cnt <= '0;
            r_wdt     <= 1'b0;
        end else if (w_cmd_ok) begin
            r_wdt_cnt <= '0;
            r_wdt     <= 1'b0;
        end else if (w_wdt_fire) begin
            r_wdt_cnt <= '0;
            r_wdt     <= 1'b1;
        end else if (w_tick && !r_wdt) begin
            r_wdt_cnt <= r_wdt_cnt + WW'(1);
        end
    end

endmodule

// File: tb/tb_bldc_duty_scheduler.sv
// tb/tb_bldc_duty_scheduler.sv - directed self-checking bench for bldc_duty_scheduler
module tb_bldc_duty_scheduler;

    localparam int NM   = 5;
    localparam int DWID = 10;
    localparam int TDIV = 16;

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_motor;
    logic [DWID-1:0]   cmd_duty;
    logic [NM-1:0]     connected;
    logic              fault_clear;
    logic [NM*DWID-1:0] duty;
    logic [NM-1:0]     en;
    logic [NM-1:0]     fault;
    logic              wdt_expired;

    int cyc;
    int n_checks = 0;
    int n_errors = 0;

    bldc_duty_scheduler #(
        .NUM_MOTORS    (NM),
        .DUTY_WIDTH    (DWID),
        .RAMP_STEP     (4),
        .TICK_DIV      (TDIV),
        .WDT_TICKS     (1600),
        .REVERSE_DWELL (16)
    ) u_dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_motor   (cmd_motor),
        .i_cmd_duty    (cmd_duty),
        .i_connected   (connected),
        .i_fault_clear (fault_clear),
        .o_duty        (duty),
        .o_en          (en),
        .o_fault       (fault),
        .o_wdt_expired (wdt_expired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DWID-1:0] d(input int i);
        return duty[i*DWID +: DWID];
    endfunction

    task automatic to_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic send(input logic [2:0] m, input logic [DWID-1:0] v);
        cmd_motor = m;
        cmd_duty  = v;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
    endtask

    // Tick n's cycle is cyc 16n-1; motor i updates on edge 16n+1+i; cyc 16n+8 is "after tick n".
    initial begin
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_motor   = '0;
        cmd_duty    = '0;
        connected   = 5'h1F;
        fault_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_duty", duty, 0);
        chk("rst_en", en, 0);
        chk("rst_fault", fault, 0);
        chk("rst_wdt", wdt_expired, 0);
        reset_n = 1'b1;

        to_cyc(8);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_en", en, 5'h1F);
        chk("idle_duty", duty, 0);
        send(3'd0, 10'd100);
        to_cyc(24);   chk("m0_t1", d(0), 10'd4);
        to_cyc(168);  chk("m0_t10", d(0), 10'd40);
        to_cyc(392);  chk("m0_t24", d(0), 10'd96);
        to_cyc(408);  chk("m0_t25", d(0), 10'd100);
        chk("others_zero", duty[NM*DWID-1:DWID], 0);
        chk("en_all", en, 5'h1F);
        to_cyc(424);  chk("m0_t26", d(0), 10'd100);

        send(3'd2, 10'd8);
        to_cyc(440);  chk("m2_up1", d(2), 10'h004);
        to_cyc(456);  chk("m2_up2", d(2), 10'h008);
        send(3'd2, 10'h208);
        to_cyc(472);  chk("rev_t1", d(2), 10'h004);
        to_cyc(488);  chk("rev_t2", d(2), 10'h000);
        to_cyc(744);  chk("rev_t18", d(2), 10'h000);
        to_cyc(760);  chk("rev_t19", d(2), 10'h204);
        to_cyc(776);  chk("rev_t20", d(2), 10'h208);

        send(3'd3, 10'd200);
        to_cyc(1560); chk("m3_t97", d(3), 10'd196);
        to_cyc(1576); chk("m3_t98", d(3), 10'd200);
        connected = 5'b10111;
        to_cyc(1577);
        chk("flt_fault", fault, 5'b01000);
        chk("flt_en", en, 5'b10111);
        chk("flt_duty3", d(3), 0);
        chk("flt_duty0", d(0), 10'd100);
        to_cyc(1578); pulse_clear();
        chk("clr_disc_fault", fault, 5'b01000);
        chk("clr_disc_en", en, 5'b10111);
        to_cyc(1580); connected = 5'h1F;
        to_cyc(1582); pulse_clear();
        chk("clr_conn_fault", fault, 0);
        to_cyc(1584); chk("clr_conn_en", en, 5'h1F);
        to_cyc(1608); chk("clr_tgt3", d(3), 0);

        send(3'd0, 10'd100);
        to_cyc(1610); send(3'd1, 10'd40);
        to_cyc(16008); send(3'd7, 10'd50);
        to_cyc(16024);
        chk("m7_d0", d(0), 10'd100);
        chk("m7_d1", d(1), 10'd40);
        chk("m7_d3", d(3), 0);
        chk("m7_d4", d(4), 0);
        chk("m7_wdt", wdt_expired, 0);

        to_cyc(27199);
        chk("wdt_pre", wdt_expired, 0);
        chk("wdt_pre_d0", d(0), 10'd100);
        chk("wdt_pre_en", en, 5'h1F);
        to_cyc(27200);
        chk("wdt_fire", wdt_expired, 1);
        chk("wdt_duty", duty, 0);
        chk("wdt_en", en, 0);
        to_cyc(27208); send(3'd1, 10'd40);
        chk("wdt_clr", wdt_expired, 0);
        chk("wdt_clr_en0", en, 0);
        to_cyc(27210); chk("wdt_clr_en1", en, 5'h1F);
        to_cyc(27224);
        chk("wdt_m1_t1", d(1), 10'd4);
        chk("wdt_m0_zero", d(0), 0);
        to_cyc(27240); chk("wdt_m1_t2", d(1), 10'd8);

        to_cyc(27252); send(3'd4, 10'd20);
        to_cyc(27256); chk("slot_old", d(4), 0);
        to_cyc(27272);
        chk("slot_new", d(4), 10'd4);
        chk("ramp_m1", d(1), 10'd16);

        #2;
        reset_n = 1'b0;
        #1;
        chk("async_duty", duty, 0);
        chk("async_en", en, 0);
        chk("async_ready", cmd_ready, 0);
        chk("async_wdt", wdt_expired, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bldc_duty_scheduler.md
# bldc_duty_scheduler

Duty-cycle sequencer in front of the per-motor BLDC drive blocks. Accepts signed duty commands from the host register interface, stores one target per motor, and ramps each motor's applied duty toward its target with a single shared ramp engine, serviced round-robin on a fixed tick. It enforces a zero-crossing dwell on direction reversal, latches per-motor hall/connection faults, and runs a command watchdog that idles all motors when the host goes silent.

## Interface
- NUM_MOTORS, 5, number of motors served.
- DUTY_WIDTH, 10, duty word width: MSB = direction (1 = reverse), low DUTY_WIDTH-1 bits = magnitude.
- RAMP_STEP, 4, maximum magnitude change per motor per tick.
- TICK_DIV, 1152, clk cycles per ramp tick (16 kHz at 18.432 MHz).
- WDT_TICKS, 1600, ticks without an accepted valid command before watchdog expiry (100 ms).
- REVERSE_DWELL, 16, ticks held at zero magnitude before a direction change.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_motor  in  3  target motor index.
- cmd_duty  in  DUTY_WIDTH  signed-magnitude target duty.
- connected  in  NUM_MOTORS  per-motor hall connected & not faulted, from the drive blocks.
- fault_clear  in  1  single-cycle pulse that clears latched faults.
- duty  out  NUM_MOTORS*DUTY_WIDTH  applied duty; motor i at [i*DUTY_WIDTH +: DUTY_WIDTH].
- en  out  NUM_MOTORS  per-motor drive enable.
- fault  out  NUM_MOTORS  latched per-motor fault.
- wdt_expired  out  1  watchdog expired.

## Operation
- Reset (async, immediate): duty, en, fault, wdt_expired, cmd_ready all 0. Targets, dwell counters, prescaler, and watchdog are cleared; FSM = IDLE. A reset asserted mid-ramp zeroes everything at once, with no ramp-down.
- cmd_ready = 1 from the first clk edge after reset_n deasserts, and stays 1.
- Command accept: target[cmd_motor] <= cmd_duty and the watchdog counter is cleared. If cmd_motor >= NUM_MOTORS, the command is accepted and dropped, and it does not kick the watchdog.
- Prescaler: counts 0..TICK_DIV-1 and emits a 1-cycle tick on wrap.
- FSM: IDLE -> UPDATE on tick. UPDATE processes motor idx = 0..NUM_MOTORS-1, one per cycle, then returns to IDLE.
- Per-motor update, with cur = applied duty and tgt = target (tgt treated as 0 when fault[i] or wdt_expired):
  - Same sign, or cur magnitude 0 with dwell 0: step magnitude toward tgt by min(RAMP_STEP, |diff|). Sign takes tgt sign when starting from 0.
  - Signs differ and cur magnitude > 0: decrease magnitude by min(RAMP_STEP, mag).
  - On the update where magnitude reaches 0 from nonzero: load dwell = REVERSE_DWELL.
  - Each update with magnitude 0 and dwell > 0: decrement dwell. The magnitude stays 0 and the sign is held.
  - Magnitude arithmetic saturates; it never wraps below 0 or above the target.
- Fault: when en[i] = 1 and connected[i] = 0, set fault[i]. On the same edge, force duty[i] = 0 and en[i] = 0; target[i] is kept.
- fault_clear: clears fault[i] and target[i] only for motors with connected[i] = 1. If connected[i] = 0 in the same cycle, the fault stays set.
- en[i] = ~fault[i] & ~wdt_expired (registered).
- Watchdog: counts ticks since the last valid accepted command. On reaching WDT_TICKS:
  - wdt_expired <= 1.
  - All targets and applied duties <= 0, all en <= 0, dwell counters cleared.
  - The next valid accepted command clears wdt_expired, and en returns on the following edge.
- Simultaneous events:
  - A command landing in the same cycle as watchdog expiry wins: the counter clears and no expiry occurs.
  - A command written in the same cycle as that motor's UPDATE slot: the slot uses the old target, and the new target applies at the next tick.

## Timing
- All outputs are registered.
- Target is visible internally 1 cycle after accept.
- Motor i's duty changes on the edge i+1 cycles after the tick cycle. All motors are updated once per tick.
- Fault: en/duty drop 1 edge after connected falls while en is high.
- Watchdog: en/duty drop on the edge following the tick that reaches WDT_TICKS.
- Ramp time from 0 to magnitude M is ceil(M/RAMP_STEP) ticks.
- Full reversal from +A to -B takes ceil(A/RAMP_STEP) + REVERSE_DWELL + ceil(B/RAMP_STEP) ticks.

## Test plan
- Reset then cmd (motor 0, +100): duty0 rises by 4 per tick and reaches 100 after 25 ticks. Other motors stay 0; en = all 1.
- Reversal on motor 2, from +8 to -8:
  - Magnitude goes 4, then 0 over 2 ticks.
  - It holds 0 for 16 ticks with the sign still forward.
  - It then reaches -4, then -8, ending at tick 20.
- Pull connected[3] low while motor 3 is at +200: next edge fault[3] = 1, en[3] = 0, duty3 = 0.
  - fault_clear while still disconnected: fault[3] stays 1.
  - fault_clear after reconnecting: fault[3] = 0 and target[3] = 0.
- No commands for 1600 ticks with motors running: wdt_expired = 1, all duty = 0, all en = 0. The next command (motor 1, +40) clears it and motor 1 ramps from 0.
- Boundary checks:
  - A cmd to motor 7 is accepted, with no target change and no watchdog kick.
  - A cmd to motor 4 in motor 4's UPDATE cycle takes effect at the next tick.
  - Asserting reset_n mid-ramp zeroes all outputs asynchronously.
